// File: rtl/booth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_pkg                                                            |
// | Shared types and helpers for the sequential radix-2 Booth multiplier |
// | Optional feature macro: BOOTH_UNSIGNED_EN                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package booth_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Internal core width: one extra bit lets unsigned operands ride the signed core.
  function automatic int booth_n(input int width);
`ifdef BOOTH_UNSIGNED_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_step                                                           |
// | One Booth iteration: conditional add/sub of M then arithmetic shift  |
// | Optional feature macro: BOOTH_UNSIGNED_EN (not used here)            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module booth_step
  import booth_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [2*N+1:0] p_in,   // {A[N:0], Q[N-1:0], q_m1}
  input  logic [N:0]     m,
  output logic [2*N+1:0] p_out
);

  logic [N:0]   w_acc;
  logic [N:0]   w_sum;
  logic [N-1:0] w_q;
  booth_op_e    w_op;

  assign w_acc = p_in[2*N+1:N+1];
  assign w_q   = p_in[N:1];
  assign w_op  = booth_decode(p_in[1], p_in[0]);

  always_comb begin
    w_sum = w_acc;
    case (w_op)
      OP_ADD:  w_sum = w_acc + m;
      OP_SUB:  w_sum = w_acc - m;
      default: w_sum = w_acc;
    endcase
  end

  // Shifting {sum, Q, q_m1} right by one drops the old q_m1; Q[0] becomes the new one.
  assign p_out = {w_sum[N], w_sum, w_q};

endmodule : booth_step
`default_nettype wire

// File: rtl/booth_seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_seq_mul                                                        |
// | Iterative radix-2 Booth multiplier with valid/ready in and out       |
// | Optional feature macro: BOOTH_UNSIGNED_EN (adds in_sgn, N=WIDTH+1)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               in_sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int N  = booth_n(WIDTH);
  localparam int PW = 2*N + 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic [N:0]       m_q, m_d;

  logic [N-1:0]     w_a_ext;
  logic [N-1:0]     w_b_ext;
  logic [PW-1:0]    w_step;

`ifdef BOOTH_UNSIGNED_EN
  assign w_a_ext = {in_sgn & in_a[WIDTH-1], in_a};
  assign w_b_ext = {in_sgn & in_b[WIDTH-1], in_b};
`else
  assign w_a_ext = in_a;
  assign w_b_ext = in_b;
`endif

  booth_step #(
    .N (N)
  ) u_step (
    .p_in  (p_q),
    .m     (m_q),
    .p_out (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = {w_a_ext[N-1], w_a_ext};
          p_d     = {{(N+1){1'b0}}, w_b_ext, 1'b0};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d   = w_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst keeps in_ready low for the whole reset pulse, not just after it.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_p     = p_q[2*WIDTH:1];

endmodule : booth_seq_mul
`default_nettype wire

// File: tb/tb_booth_seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_booth_seq_mul                                                     |
// | Directed and random checks of booth_seq_mul against an integer model |
// | Optional feature macro: BOOTH_UNSIGNED_EN                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_booth_seq_mul;

  localparam int WIDTH = 6;
`ifdef BOOTH_UNSIGNED_EN
  localparam int NLAT = WIDTH + 1;
`else
  localparam int NLAT = WIDTH;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic               in_sgn = 1'b1;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2*WIDTH-1:0] out_p;

  int n_checks = 0;
  int n_fails  = 0;

  booth_seq_mul #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef BOOTH_UNSIGNED_EN
    .in_sgn    (in_sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer product of the operands as the chosen signedness reads them.
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    longint va, vb, prod;
`ifdef BOOTH_UNSIGNED_EN
    if (sgn) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
    end else begin
      va = longint'(a);
      vb = longint'(b);
    end
`else
    va = longint'($signed(a));
    vb = longint'($signed(b));
    if (sgn) prod = 0;
`endif
    prod = va * vb;
    return prod[2*WIDTH-1:0];
  endfunction

  // One complete transaction; inputs driven and outputs sampled on the falling edge.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sgn, input logic [2*WIDTH-1:0] exp, input int hold);
    int n;
    logic [2*WIDTH-1:0] held;
    n = 0;
    check({tag, "_in_ready"}, in_ready, 1);
    in_a = a; in_b = b; in_sgn = sgn; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_sgn = ~sgn;
    while (!out_valid && n < 200) begin
      if (n == 2) begin
        in_valid = 1'b1;
        check({tag, "_busy_ready"}, in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end
    check({tag, "_latency"}, n, NLAT);
    check({tag, "_p"}, out_p, exp);
    held = out_p;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_p"}, out_p, held);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    int               rh;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    @(negedge clk);

    // Directed signed products
    run_op("m7x-3",    6'd7,  6'h3D, 1'b1, 12'hFEB, 0);
    run_op("m-32x-32", 6'h20, 6'h20, 1'b1, 12'h400, 0);
    run_op("m0x-1",    6'd0,  6'h3F, 1'b1, 12'h000, 0);
    run_op("m31x31",   6'd31, 6'd31, 1'b1, 12'h3C1, 0);
    run_op("bp5",      6'd9,  6'h39, 1'b1, ref_mul(6'd9, 6'h39, 1'b1), 5);

    // Reset during RUN discards the operation
    in_a = 6'd13; in_b = 6'd11; in_sgn = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", in_ready, 1);
    check("midrst_rel_valid", out_valid, 0);
    @(negedge clk);
    run_op("m5x5", 6'd5, 6'd5, 1'b1, 12'h019, 0);

`ifdef BOOTH_UNSIGNED_EN
    run_op("u63x63", 6'd63, 6'd63, 1'b0, 12'hF81, 0);
    run_op("s63x63", 6'd63, 6'd63, 1'b1, 12'h001, 0);
`endif

    // Random operands against the model
    for (int k = 0; k < 24; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b1;
`endif
      rh = int'($urandom_range(0, 3));
      run_op("rand", ra, rb, rs, ref_mul(ra, rb, rs), rh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_booth_seq_mul
`default_nettype wire
